// File: rtl/mant_round_pipe.sv
// mant_round_pipe: rounds a normalized mantissa to MAN_WIDTH fraction bits
// (round-to-nearest-even). It also folds the normalizer's exponent adjustment
// into the base exponent and saturates the result exponent. Two register
// stages sit between the normalizer and the posit encoder, with full
// valid/ready backpressure.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   flush_i                synchronous flush of all in-flight transactions
//   valid_i / ready_o      input handshake (ready_o is combinational)
//   sign_i, zero_i         result sign, exact-zero marker
//   exp_i, exp_adjust_i    signed base exponent, signed normalization adjust
//   mant_i                 normalized mantissa, MSB is the hidden bit
//   valid_o / ready_i      output handshake
//   sign_o, zero_o         registered sign and zero flag
//   exp_o, frac_o          saturated exponent, rounded fraction (no hidden bit)
//   inexact_o, ovf_o, unf_o  rounding lost bits, saturated high, saturated low
module mant_round_pipe #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAN_WIDTH = 4,
  parameter int unsigned EXP_WIDTH = 6,
  parameter int unsigned ADJ_WIDTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic                 sign_i,
  input  logic                 zero_i,
  input  logic [EXP_WIDTH-1:0] exp_i,
  input  logic [ADJ_WIDTH-1:0] exp_adjust_i,
  input  logic [WIDTH-1:0]     mant_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 sign_o,
  output logic                 zero_o,
  output logic [EXP_WIDTH-1:0] exp_o,
  output logic [MAN_WIDTH-1:0] frac_o,
  output logic                 inexact_o,
  output logic                 ovf_o,
  output logic                 unf_o
);

  // Kept bits include the hidden bit; the rounding sum gets one extra carry bit.
  localparam int unsigned KW       = MAN_WIDTH + 1;
  localparam int unsigned RW       = MAN_WIDTH + 2;
  // Exponent sum is widened by two bits so base + adjust + carry never wraps.
  localparam int unsigned EW2      = EXP_WIDTH + 2;
  localparam int unsigned LOW_BITS = WIDTH - MAN_WIDTH - 2;

  // Bits below the guard position; empty mask when there are none.
  localparam logic [WIDTH-1:0] STICKY_MASK = {WIDTH{1'b1}} >> (WIDTH - LOW_BITS);

  localparam logic signed [EW2-1:0] EMAX_X = EW2'((1 << (EXP_WIDTH - 1)) - 1);
  localparam logic signed [EW2-1:0] EMIN_X = ~EMAX_X;

  // Stage 1 registers
  logic                  s1_valid_q,    s1_valid_d;
  logic                  s1_sign_q,     s1_sign_d;
  logic                  s1_zero_q,     s1_zero_d;
  logic [KW-1:0]         s1_kept_q,     s1_kept_d;
  logic                  s1_round_up_q, s1_round_up_d;
  logic                  s1_inexact_q,  s1_inexact_d;
  logic signed [EW2-1:0] s1_esum_q,     s1_esum_d;

  // Stage 2 (output) registers
  logic                  s2_valid_q,    s2_valid_d;
  logic                  out_sign_q,    out_sign_d;
  logic                  out_zero_q,    out_zero_d;
  logic [EXP_WIDTH-1:0]  out_exp_q,     out_exp_d;
  logic [MAN_WIDTH-1:0]  out_frac_q,    out_frac_d;
  logic                  out_inexact_q, out_inexact_d;
  logic                  out_ovf_q,     out_ovf_d;
  logic                  out_unf_q,     out_unf_d;

  logic s1_adv;
  logic in_fire;

  // Handshake: stage 2 frees when empty or drained; flush blocks intake.
  always_comb begin
    s1_adv  = ~s2_valid_q | ready_i;
    ready_o = ~flush_i & (~s1_valid_q | s1_adv);
    in_fire = valid_i & ready_o;
  end

  // Stage 1: split mantissa into kept/guard/sticky and sum the exponents.
  logic [KW-1:0]         st1_kept;
  logic                  st1_guard;
  logic                  st1_sticky;
  logic signed [EW2-1:0] st1_esum;

  always_comb begin
    st1_kept   = mant_i[WIDTH-1 -: KW];
    st1_guard  = mant_i[LOW_BITS];
    st1_sticky = |(mant_i & STICKY_MASK);
    st1_esum   = {{(EW2-EXP_WIDTH){exp_i[EXP_WIDTH-1]}}, exp_i}
               + {{(EW2-ADJ_WIDTH){exp_adjust_i[ADJ_WIDTH-1]}}, exp_adjust_i};

    s1_valid_d    = s1_valid_q;
    s1_sign_d     = s1_sign_q;
    s1_zero_d     = s1_zero_q;
    s1_kept_d     = s1_kept_q;
    s1_round_up_d = s1_round_up_q;
    s1_inexact_d  = s1_inexact_q;
    s1_esum_d     = s1_esum_q;

    if (flush_i) begin
      s1_valid_d = 1'b0;
    end else if (in_fire) begin
      s1_valid_d    = 1'b1;
      s1_sign_d     = sign_i;
      s1_zero_d     = zero_i;
      s1_kept_d     = st1_kept;
      // Round half to even: a tie rounds up only when the kept LSB is odd.
      s1_round_up_d = st1_guard & (st1_sticky | st1_kept[0]);
      // A zero result carries no rounding information.
      s1_inexact_d  = ~zero_i & (st1_guard | st1_sticky);
      s1_esum_d     = st1_esum;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  // Stage 2: apply rounding, renormalize on carry-out, saturate the exponent.
  logic [RW-1:0]         st2_r;
  logic                  st2_carry;
  logic [MAN_WIDTH-1:0]  st2_frac;
  logic signed [EW2-1:0] st2_exp;
  logic [EXP_WIDTH-1:0]  st2_res_exp;
  logic [MAN_WIDTH-1:0]  st2_res_frac;
  logic                  st2_res_ovf;
  logic                  st2_res_unf;

  always_comb begin
    st2_r     = RW'(s1_kept_q) + RW'(s1_round_up_q);
    st2_carry = st2_r[RW-1];
    // Carry-out means the mantissa became 10.000..; shift right by one.
    st2_frac  = st2_carry ? st2_r[MAN_WIDTH:1] : st2_r[MAN_WIDTH-1:0];
    st2_exp   = s1_esum_q + EW2'(st2_carry);

    st2_res_exp  = st2_exp[EXP_WIDTH-1:0];
    st2_res_frac = st2_frac;
    st2_res_ovf  = 1'b0;
    st2_res_unf  = 1'b0;

    if (s1_zero_q) begin
      st2_res_exp  = '0;
      st2_res_frac = '0;
    end else if (st2_exp > EMAX_X) begin
      st2_res_exp  = EMAX_X[EXP_WIDTH-1:0];
      st2_res_frac = '1;
      st2_res_ovf  = 1'b1;
    end else if (st2_exp < EMIN_X) begin
      st2_res_exp  = EMIN_X[EXP_WIDTH-1:0];
      st2_res_frac = '0;
      st2_res_unf  = 1'b1;
    end

    s2_valid_d    = s2_valid_q;
    out_sign_d    = out_sign_q;
    out_zero_d    = out_zero_q;
    out_exp_d     = out_exp_q;
    out_frac_d    = out_frac_q;
    out_inexact_d = out_inexact_q;
    out_ovf_d     = out_ovf_q;
    out_unf_d     = out_unf_q;

    if (flush_i) begin
      s2_valid_d = 1'b0;
    end else if (s1_adv) begin
      s2_valid_d = s1_valid_q;
      // Keep the last result on the outputs when a bubble moves in.
      if (s1_valid_q) begin
        out_sign_d    = s1_sign_q;
        out_zero_d    = s1_zero_q;
        out_exp_d     = st2_res_exp;
        out_frac_d    = st2_res_frac;
        out_inexact_d = s1_inexact_q;
        out_ovf_d     = st2_res_ovf;
        out_unf_d     = st2_res_unf;
      end
    end
  end

  // Pipeline state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q    <= 1'b0;
      s1_sign_q     <= 1'b0;
      s1_zero_q     <= 1'b0;
      s1_kept_q     <= '0;
      s1_round_up_q <= 1'b0;
      s1_inexact_q  <= 1'b0;
      s1_esum_q     <= '0;
      s2_valid_q    <= 1'b0;
      out_sign_q    <= 1'b0;
      out_zero_q    <= 1'b0;
      out_exp_q     <= '0;
      out_frac_q    <= '0;
      out_inexact_q <= 1'b0;
      out_ovf_q     <= 1'b0;
      out_unf_q     <= 1'b0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_sign_q     <= s1_sign_d;
      s1_zero_q     <= s1_zero_d;
      s1_kept_q     <= s1_kept_d;
      s1_round_up_q <= s1_round_up_d;
      s1_inexact_q  <= s1_inexact_d;
      s1_esum_q     <= s1_esum_d;
      s2_valid_q    <= s2_valid_d;
      out_sign_q    <= out_sign_d;
      out_zero_q    <= out_zero_d;
      out_exp_q     <= out_exp_d;
      out_frac_q    <= out_frac_d;
      out_inexact_q <= out_inexact_d;
      out_ovf_q     <= out_ovf_d;
      out_unf_q     <= out_unf_d;
    end
  end

  assign valid_o   = s2_valid_q;
  assign sign_o    = out_sign_q;
  assign zero_o    = out_zero_q;
  assign exp_o     = out_exp_q;
  assign frac_o    = out_frac_q;
  assign inexact_o = out_inexact_q;
  assign ovf_o     = out_ovf_q;
  assign unf_o     = out_unf_q;

endmodule

// File: tb/tb_mant_round_pipe.sv
// Testbench for mant_round_pipe: table vectors, a behavioral rounding model,
// and a scoreboard queue. It also covers backpressure, reset and flush corners.
module tb_mant_round_pipe;

  localparam int unsigned WIDTH     = 8;
  localparam int unsigned MAN_WIDTH = 4;
  localparam int unsigned EXP_WIDTH = 6;
  localparam int unsigned ADJ_WIDTH = 4;
  localparam int          NTBL      = 13;

  logic                 clk_i = 1'b0;
  logic                 rst_ni = 1'b0;
  logic                 flush_i = 1'b0;
  logic                 valid_i = 1'b0;
  logic                 ready_o;
  logic                 sign_i = 1'b0;
  logic                 zero_i = 1'b0;
  logic [EXP_WIDTH-1:0] exp_i = '0;
  logic [ADJ_WIDTH-1:0] exp_adjust_i = '0;
  logic [WIDTH-1:0]     mant_i = '0;
  logic                 valid_o;
  logic                 ready_i = 1'b1;
  logic                 sign_o;
  logic                 zero_o;
  logic [EXP_WIDTH-1:0] exp_o;
  logic [MAN_WIDTH-1:0] frac_o;
  logic                 inexact_o;
  logic                 ovf_o;
  logic                 unf_o;

  mant_round_pipe #(
    .WIDTH(WIDTH), .MAN_WIDTH(MAN_WIDTH), .EXP_WIDTH(EXP_WIDTH), .ADJ_WIDTH(ADJ_WIDTH)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .valid_i(valid_i), .ready_o(ready_o),
    .sign_i(sign_i), .zero_i(zero_i), .exp_i(exp_i),
    .exp_adjust_i(exp_adjust_i), .mant_i(mant_i),
    .valid_o(valid_o), .ready_i(ready_i),
    .sign_o(sign_o), .zero_o(zero_o), .exp_o(exp_o), .frac_o(frac_o),
    .inexact_o(inexact_o), .ovf_o(ovf_o), .unf_o(unf_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic                 sign;
    logic                 zero;
    logic [EXP_WIDTH-1:0] exp;
    logic [MAN_WIDTH-1:0] frac;
    logic                 inexact;
    logic                 ovf;
    logic                 unf;
  } res_t;

  typedef struct {
    logic       sign;
    logic       zero;
    int         e;
    int         adj;
    logic [7:0] mant;
    res_t       x;
  } vec_t;

  res_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   n_acc  = 0;
  int   cyc    = 0;
  bit   done   = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic vec_t mkv(input int sg, input int zr, input int e, input int adj,
                               input logic [7:0] mant, input int xe, input int xf,
                               input int xi, input int xo, input int xu);
    vec_t v;
    v.sign = 1'(sg); v.zero = 1'(zr); v.e = e; v.adj = adj; v.mant = mant;
    v.x.sign = 1'(sg); v.x.zero = 1'(zr);
    v.x.exp = EXP_WIDTH'(xe); v.x.frac = MAN_WIDTH'(xf);
    v.x.inexact = 1'(xi); v.x.ovf = 1'(xo); v.x.unf = 1'(xu);
    return v;
  endfunction

  // Behavioral reference: integer arithmetic on the 5 kept bits.
  function automatic res_t model(input vec_t v);
    res_t r;
    int   e, k;
    bit   g, s;
    r = '0;
    r.sign = v.sign;
    if (v.zero) begin
      r.zero = 1'b1;
      return r;
    end
    e = v.e + v.adj;
    k = int'(v.mant) / 8;
    g = v.mant[2];
    s = (v.mant[1:0] != 2'b00);
    r.inexact = g | s;
    if (g && (s || (k % 2 == 1))) k++;
    if (k == 32) begin k = 16; e++; end
    if (e > 31) begin e = 31; k = 31; r.ovf = 1'b1; end
    else if (e < -32) begin e = -32; k = 16; r.unf = 1'b1; end
    r.exp  = EXP_WIDTH'(e);
    r.frac = MAN_WIDTH'(k % 16);
    return r;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    v.sign = 1'($urandom_range(0, 1));
    v.zero = ($urandom_range(0, 7) == 0);
    v.e    = int'($urandom_range(0, 63)) - 32;
    v.adj  = int'($urandom_range(0, 15)) - 8;
    v.mant = 8'h80 | 8'($urandom_range(0, 255));
    v.x    = model(v);
    return v;
  endfunction

  task automatic drive(input vec_t v);
    int n   = 0;
    bit acc = 1'b0;
    sign_i = v.sign; zero_i = v.zero;
    exp_i = EXP_WIDTH'(v.e); exp_adjust_i = ADJ_WIDTH'(v.adj); mant_i = v.mant;
    valid_i = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk_i);
      acc = ready_o;
      @(posedge clk_i);
      #1;
      n++;
    end
    valid_i = 1'b0;
    if (acc) begin
      exp_q.push_back(v.x);
      n_acc++;
    end else begin
      chk("accept_timeout", 0, 1);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk_i);
      n++;
    end
    #1;
    chk("drain", exp_q.size(), 0);
  endtask

  // Output monitor: scoreboard compare on transfer, hold check while stalled.
  res_t prev_out;
  bit   prev_stall = 1'b0;
  always @(negedge clk_i) begin
    res_t cur;
    res_t x;
    cur = {sign_o, zero_o, exp_o, frac_o, inexact_o, ovf_o, unf_o};
    if (!rst_ni) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", int'(valid_o), 1);
        chk("stall_hold", int'(cur), int'(prev_out));
      end
      if (valid_o && ready_i && !flush_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          x = exp_q.pop_front();
          chk("sign",    int'(cur.sign),    int'(x.sign));
          chk("zero",    int'(cur.zero),    int'(x.zero));
          chk("exp",     int'($signed(cur.exp)), int'($signed(x.exp)));
          chk("frac",    int'(cur.frac),    int'(x.frac));
          chk("inexact", int'(cur.inexact), int'(x.inexact));
          chk("ovf",     int'(cur.ovf),     int'(x.ovf));
          chk("unf",     int'(cur.unf),     int'(x.unf));
        end
      end
      prev_stall = valid_o && !ready_i && !flush_i;
      prev_out   = cur;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[NTBL];
    vec_t bp[4];
    vec_t v;
    int   t0;

    tbl[0]  = mkv(0, 0,   3,  0, 8'b1011_0100,   3,  6, 1, 0, 0);
    tbl[1]  = mkv(1, 0,  -5,  1, 8'b1011_1100,  -4,  8, 1, 0, 0);
    tbl[2]  = mkv(0, 0,  10, -2, 8'b1111_1100,   9,  0, 1, 0, 0);
    tbl[3]  = mkv(0, 0,  30,  2, 8'h80,         31, 15, 0, 1, 0);
    tbl[4]  = mkv(1, 0, -32, -1, 8'h80,        -32,  0, 0, 0, 1);
    tbl[5]  = mkv(0, 0,   0,  0, 8'b1010_1000,   0,  5, 0, 0, 0);
    tbl[6]  = mkv(0, 0,  -1,  0, 8'b1000_0101,  -1,  1, 1, 0, 0);
    tbl[7]  = mkv(0, 0,   5,  3, 8'b1000_1011,   8,  1, 1, 0, 0);
    tbl[8]  = mkv(1, 1,  12,  3, 8'h55,          0,  0, 0, 0, 0);
    tbl[9]  = mkv(0, 0,  31,  0, 8'hFC,         31, 15, 1, 1, 0);
    tbl[10] = mkv(0, 0, -32,  0, 8'h80,        -32,  0, 0, 0, 0);
    tbl[11] = mkv(0, 0,  28,  3, 8'hC0,         31,  8, 0, 0, 0);
    tbl[12] = mkv(0, 0, -32, -1, 8'hFC,        -32,  0, 1, 0, 0);

    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_valid_o", int'(valid_o), 0);
    chk("rst_outputs", int'({sign_o, zero_o, exp_o, frac_o, inexact_o, ovf_o, unf_o}), 0);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    chk("rst_ready_o", int'(ready_o), 1);

    // Two-cycle latency on an empty pipe
    drive(tbl[0]);
    chk("lat_cycle1", int'(valid_o), 0);
    @(posedge clk_i);
    #1;
    chk("lat_cycle2", int'(valid_o), 1);
    wait_drain();

    // Remaining table vectors back-to-back at full throughput
    t0 = cyc;
    for (int i = 1; i < NTBL; i++) drive(tbl[i]);
    chk("throughput_cycles", cyc - t0, NTBL - 1);
    wait_drain();

    // Backpressure: 4 inputs, downstream stalled for 4 cycles
    for (int i = 0; i < 4; i++) bp[i] = rand_vec();
    n_acc   = 0;
    ready_i = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) drive(bp[i]);
      end
      begin
        repeat (4) @(posedge clk_i);
        #2;
        chk("bp_ready_low", int'(ready_o), 0);
        chk("bp_accepts", n_acc, 2);
        chk("bp_valid_o", int'(valid_o), 1);
        ready_i = 1'b1;
      end
    join
    wait_drain();
    chk("bp_total_accepts", n_acc, 4);

    // Random stream with random downstream stalls and input gaps
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk_i);
            #1;
          end
          v = rand_vec();
          drive(v);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk_i);
          #1;
          ready_i = ($urandom_range(0, 3) != 0);
        end
        ready_i = 1'b1;
      end
    join
    wait_drain();

    // Asynchronous reset with both stages full
    ready_i = 1'b0;
    drive(rand_vec());
    drive(rand_vec());
    chk("rst_pre_valid", int'(valid_o), 1);
    #1;
    rst_ni = 1'b0;
    #1;
    chk("rst_async_valid", int'(valid_o), 0);
    chk("rst_async_outputs", int'({sign_o, zero_o, exp_o, frac_o, inexact_o, ovf_o, unf_o}), 0);
    exp_q.delete();
    ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i);
      #1;
      chk("rst_no_stale", int'(valid_o), 0);
    end
    drive(tbl[1]);
    wait_drain();

    // Flush with both stages full and an input offered in the flush cycle
    ready_i = 1'b0;
    drive(rand_vec());
    drive(rand_vec());
    chk("flush_pre_valid", int'(valid_o), 1);
    flush_i = 1'b1;
    valid_i = 1'b1;
    sign_i = 1'b1; zero_i = 1'b0; exp_i = EXP_WIDTH'(7); exp_adjust_i = '0; mant_i = 8'hA4;
    @(negedge clk_i);
    chk("flush_ready_low", int'(ready_o), 0);
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    valid_i = 1'b0;
    chk("flush_valid_o", int'(valid_o), 0);
    exp_q.delete();
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_i);
      #1;
      chk("flush_no_stale", int'(valid_o), 0);
    end
    drive(tbl[2]);
    drive(tbl[3]);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
